// File: rtl/mem_access.sv
// Load/store unit: carries one exec memory request at a time over a req/ack bus and returns aligned load data.
// Optional MEM_ACCESS_RDATA_BYPASS_EN returns ack data combinationally and skips the DONE state.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_en_in,
  input  logic              mem_write_en_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [31:0]       mem_wdata_in,
  input  logic [3:0]        mem_byte_num_in,
  output logic              mem_valid_out,
  output logic [31:0]       mem_rdata_out,
  output logic              mem_err_out,
  output logic              stall_out,
  output logic              bus_req_out,
  output logic              bus_we_out,
  output logic [ADDR_W-1:0] bus_addr_out,
  output logic [31:0]       bus_wdata_out,
  output logic [3:0]        bus_be_out,
  input  logic              bus_ack_in,
  input  logic [31:0]       bus_rdata_in
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_p1;
  logic [31:0]        wdata_p1;
  logic [3:0]         mask_p1;
  logic               we_p1;
  logic [31:0]        rdata_p2;
  logic               accept;
  logic               ack_busy;
  logic               timeout_hit;
  logic [31:0]        ack_data;

  function automatic logic [31:0] align_rdata(input logic [31:0] d, input logic [1:0] ofs);
    return d >> {ofs, 3'b000};
  endfunction

  function automatic logic [31:0] align_wdata(input logic [31:0] d, input logic [1:0] ofs);
    return d << {ofs, 3'b000};
  endfunction

  function automatic logic [3:0] align_be(input logic [3:0] m, input logic [1:0] ofs);
    return m << ofs;
  endfunction

  assign accept      = (state == IDLE) && (mem_read_en_in || mem_write_en_in);
  assign ack_busy    = (state == BUSY) && bus_ack_in;
  assign timeout_hit = TO_EN && (state == BUSY) && !bus_ack_in && (cnt == CNT_LAST);
  // Stores complete with zero read data.
  assign ack_data    = we_p1 ? 32'h0 : align_rdata(bus_rdata_in, addr_p1[1:0]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: begin
        if (bus_ack_in) begin
`ifdef MEM_ACCESS_RDATA_BYPASS_EN
          state_nxt = IDLE;
`else
          state_nxt = DONE;
`endif
        end else if (timeout_hit) begin
          state_nxt = ERR;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_req_out   = (state == BUSY);
    bus_we_out    = 1'b0;
    bus_addr_out  = '0;
    bus_wdata_out = '0;
    bus_be_out    = '0;
    if (state == BUSY) begin
      bus_we_out    = we_p1;
      bus_addr_out  = {addr_p1[ADDR_W-1:2], 2'b00};
      bus_wdata_out = align_wdata(wdata_p1, addr_p1[1:0]);
      bus_be_out    = we_p1 ? align_be(mask_p1, addr_p1[1:0]) : 4'b1111;
    end
    mem_valid_out = (state == DONE) || (state == ERR);
    mem_err_out   = (state == ERR);
    mem_rdata_out = rdata_p2;
    stall_out     = accept || (state == BUSY);
`ifdef MEM_ACCESS_RDATA_BYPASS_EN
    if (ack_busy) begin
      mem_valid_out = 1'b1;
      mem_rdata_out = ack_data;
      stall_out     = 1'b0;
    end
`endif
  end

  // Stage p0 -> p1: control state, timeout counter, returned data
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rdata_p2 <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (ack_busy) begin
        rdata_p2 <= ack_data;
      end else if (timeout_hit) begin
        rdata_p2 <= '0;
      end
    end
  end

  // Stage p0 -> p1: request capture
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1  <= mem_addr_in;
      wdata_p1 <= mem_wdata_in;
      mask_p1  <= mem_byte_num_in;
      we_p1    <= mem_write_en_in;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: table of directed transactions, randomized transactions against an
// arithmetic reference model, and hand-written reset/timeout sequences.
module tb_mem_access;

  localparam int TO = 4;
`ifdef MEM_ACCESS_RDATA_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_en_in, mem_write_en_in;
  logic [31:0] mem_addr_in, mem_wdata_in;
  logic [3:0]  mem_byte_num_in;
  logic        mem_valid_out, mem_err_out, stall_out;
  logic [31:0] mem_rdata_out;
  logic        bus_req_out, bus_we_out;
  logic [31:0] bus_addr_out, bus_wdata_out;
  logic [3:0]  bus_be_out;
  logic        bus_ack_in;
  logic [31:0] bus_rdata_in;

  mem_access #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
    .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in), .mem_byte_num_in(mem_byte_num_in),
    .mem_valid_out(mem_valid_out), .mem_rdata_out(mem_rdata_out), .mem_err_out(mem_err_out),
    .stall_out(stall_out), .bus_req_out(bus_req_out), .bus_we_out(bus_we_out),
    .bus_addr_out(bus_addr_out), .bus_wdata_out(bus_wdata_out), .bus_be_out(bus_be_out),
    .bus_ack_in(bus_ack_in), .bus_rdata_in(bus_rdata_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          delay;
    logic [31:0] bus_rdata;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int          nvec = 0;
  int          nfail = 0;
  string       cur_name;
  logic [31:0] last_rdata = '0;
  int          req_rises = 0;
  logic        req_prev = 1'b0;

  always @(negedge clk) begin
    if (bus_req_out && !req_prev) req_rises++;
    req_prev = bus_req_out;
  end

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s/%s: got %h, expected %h", cur_name, what, act, exp);
    end
  endtask

  // Reference model: expected bus beat and result from byte-address arithmetic.
  function automatic vec_t model(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] mask,
                                 input int delay, input logic [31:0] brd);
    vec_t v;
    longint unsigned ofs, lane, bytescale;
    ofs       = longint'(addr) % 4;
    lane      = 1;
    bytescale = 1;
    for (int k = 0; k < int'(ofs); k++) begin
      lane      = lane * 2;
      bytescale = bytescale * 256;
    end
    v.rd        = rd;
    v.wr        = wr;
    v.addr      = addr;
    v.wdata     = wdata;
    v.mask      = mask;
    v.delay     = delay;
    v.bus_rdata = brd;
    v.exp_we    = wr;
    v.exp_addr  = 32'(longint'(addr) - ofs);
    v.exp_be    = wr ? 4'((longint'(mask) * lane) % 16) : 4'hF;
    v.exp_wdata = 32'((longint'(wdata) * bytescale) % 64'h1_0000_0000);
    v.exp_err   = (delay >= TO);
    v.exp_rdata = (v.exp_err || wr) ? 32'h0 : 32'(longint'(brd) / bytescale);
    return v;
  endfunction

  // Runs one transaction; entered and left just after a rising edge with the DUT idle.
  task automatic run_txn(input vec_t v);
    bit acked;
    mem_read_en_in  = v.rd;
    mem_write_en_in = v.wr;
    mem_addr_in     = v.addr;
    mem_wdata_in    = v.wdata;
    mem_byte_num_in = v.mask;
    @(negedge clk);
    chk("stall_on_request", 32'(stall_out), 32'h1);
    chk("req_in_idle", 32'(bus_req_out), 32'h0);
    chk("valid_in_idle", 32'(mem_valid_out), 32'h0);
    chk("rdata_hold", mem_rdata_out, last_rdata);
    @(posedge clk); #1;
    mem_read_en_in  = 1'b0;
    mem_write_en_in = 1'b0;
    mem_addr_in     = $urandom;
    mem_wdata_in    = $urandom;
    acked = 1'b0;
    for (int i = 0; i < TO; i++) begin
      if (i == v.delay) begin
        bus_ack_in   = 1'b1;
        bus_rdata_in = v.bus_rdata;
      end
      @(negedge clk);
      chk("req_busy", 32'(bus_req_out), 32'h1);
      if (i == 0) begin
        chk("bus_we", 32'(bus_we_out), 32'(v.exp_we));
        chk("bus_addr", bus_addr_out, v.exp_addr);
        chk("bus_be", 32'(bus_be_out), 32'(v.exp_be));
        if (v.exp_we) chk("bus_wdata", bus_wdata_out, v.exp_wdata);
      end
      if (i == v.delay && BYP) begin
        chk("bypass_valid", 32'(mem_valid_out), 32'h1);
        chk("bypass_rdata", mem_rdata_out, v.exp_rdata);
        chk("bypass_stall", 32'(stall_out), 32'h0);
      end else begin
        chk("stall_busy", 32'(stall_out), 32'h1);
        chk("valid_busy", 32'(mem_valid_out), 32'h0);
      end
      @(posedge clk); #1;
      bus_ack_in   = 1'b0;
      bus_rdata_in = $urandom;
      if (i == v.delay) begin
        acked = 1'b1;
        break;
      end
    end
    if (!acked || !BYP) begin
      @(negedge clk);
      chk("valid_pulse", 32'(mem_valid_out), 32'h1);
      chk("err", 32'(mem_err_out), 32'(v.exp_err));
      chk("rdata", mem_rdata_out, v.exp_rdata);
      chk("stall_done", 32'(stall_out), 32'h0);
      chk("req_done", 32'(bus_req_out), 32'h0);
      @(posedge clk); #1;
      if (!acked) begin
        bus_ack_in   = 1'b1;
        bus_rdata_in = $urandom;
        @(negedge clk);
        chk("late_ack_valid", 32'(mem_valid_out), 32'h0);
        chk("late_ack_req", 32'(bus_req_out), 32'h0);
        @(posedge clk); #1;
        bus_ack_in = 1'b0;
      end
    end
    last_rdata = v.exp_rdata;
  endtask

  vec_t tbl[9];
  vec_t rv;
  int   rises0;

  initial begin
    //        rd    wr    addr          wdata         mask   dly ack_rdata     we    exp_addr      be     exp_wdata     exp_rdata     err
    tbl[0] = '{1'b1, 1'b0, 32'h0000_1002, 32'h0,        4'h0, 3, 32'hAABBCCDD, 1'b0, 32'h0000_1000, 4'hF, 32'h0,        32'h0000AABB, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h0000_2001, 32'h0000_00EF, 4'h1, 0, 32'h5555AAAA, 1'b1, 32'h0000_2000, 4'h2, 32'h0000EF00, 32'h0,        1'b0};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        4'h0, 1, 32'h11223344, 1'b0, 32'h0000_0010, 4'hF, 32'h0,        32'h11223344, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 32'h0000_0014, 32'hCAFEBABE, 4'hF, 1, 32'h0,        1'b1, 32'h0000_0014, 4'hF, 32'hCAFEBABE, 32'h0,        1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_3003, 32'h0,        4'h0, 9, 32'h0,        1'b0, 32'h0000_3000, 4'hF, 32'h0,        32'h0,        1'b1};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        4'h0, 0, 32'h12345678, 1'b0, 32'h0000_0000, 4'hF, 32'h0,        32'h12345678, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 32'h0000_0007, 32'h0000BEEF, 4'h3, 2, 32'h0,        1'b1, 32'h0000_0004, 4'h8, 32'hEF000000, 32'h0,        1'b0};
    tbl[7] = '{1'b1, 1'b0, 32'h0000_0005, 32'h0,        4'h0, 2, 32'h89ABCDEF, 1'b0, 32'h0000_0004, 4'hF, 32'h0,        32'h0089ABCD, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 32'h0000_0008, 32'h01020304, 4'hF, 0, 32'hFFFFFFFF, 1'b1, 32'h0000_0008, 4'hF, 32'h01020304, 32'h0,        1'b0};

    rst = 1'b1;
    mem_read_en_in = 1'b0; mem_write_en_in = 1'b0;
    mem_addr_in = '0; mem_wdata_in = '0; mem_byte_num_in = '0;
    bus_ack_in = 1'b0; bus_rdata_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cur_name = "reset";
    chk("valid", 32'(mem_valid_out), 32'h0);
    chk("rdata", mem_rdata_out, 32'h0);
    chk("err", 32'(mem_err_out), 32'h0);
    chk("stall", 32'(stall_out), 32'h0);
    chk("req", 32'(bus_req_out), 32'h0);
    chk("we", 32'(bus_we_out), 32'h0);
    chk("addr", bus_addr_out, 32'h0);
    chk("wdata", bus_wdata_out, 32'h0);
    chk("be", 32'(bus_be_out), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    rises0 = req_rises;
    for (int t = 0; t < 9; t++) begin
      cur_name = $sformatf("tbl%0d", t);
      run_txn(tbl[t]);
    end
    @(negedge clk);
    cur_name = "table";
    chk("bus_request_count", 32'(req_rises - rises0), 32'd9);
    @(posedge clk); #1;

    rises0 = req_rises;
    for (int r = 0; r < 40; r++) begin
      logic [3:0] m;
      case ($urandom_range(0, 2))
        0:       m = 4'b0001;
        1:       m = 4'b0011;
        default: m = 4'b1111;
      endcase
      rv = model(1'($urandom), 1'($urandom), $urandom, $urandom, m,
                 int'($urandom_range(0, 5)), $urandom);
      if (!rv.rd && !rv.wr) begin
        rv = model(1'b1, 1'b0, rv.addr, rv.wdata, m, rv.delay, rv.bus_rdata);
      end
      cur_name = $sformatf("rand%0d", r);
      run_txn(rv);
    end
    @(negedge clk);
    cur_name = "random";
    chk("bus_request_count", 32'(req_rises - rises0), 32'd40);
    @(posedge clk); #1;

    // Reset two cycles into BUSY, then an ack that must be ignored.
    cur_name = "reset_busy";
    mem_read_en_in = 1'b1;
    mem_addr_in    = 32'h40;
    @(posedge clk); #1;
    mem_read_en_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("req_before_reset", 32'(bus_req_out), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst          = 1'b0;
    bus_ack_in   = 1'b1;
    bus_rdata_in = 32'hDEADBEEF;
    @(negedge clk);
    chk("req", 32'(bus_req_out), 32'h0);
    chk("valid", 32'(mem_valid_out), 32'h0);
    chk("stall", 32'(stall_out), 32'h0);
    chk("rdata", mem_rdata_out, 32'h0);
    chk("addr", bus_addr_out, 32'h0);
    chk("be", 32'(bus_be_out), 32'h0);
    @(posedge clk); #1;
    bus_ack_in = 1'b0;
    @(negedge clk);
    chk("late_ack_valid", 32'(mem_valid_out), 32'h0);
    chk("late_ack_rdata", mem_rdata_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
